ram_io_responder: RTL and testbench
===================================

// Module: ram_io_responder
// PURPOSE
//  Responder end of the byte-serial RAM bus driven by the memory controller: one address/rw/data per cycle,
//  read data returned next cycle. Backs normal addresses with a byte RAM; decodes IO space (addr[17:16]==2'b11):
//  0x30000 write pushes a TX byte, 0x30000 read pops an RX byte, 0x30004 write raises program-end.
//  Drives the uart-full flag the controller checks before IO writes. Sits between memCtrl and the host link.
// PARAMETERS
//  ADDR_WIDTH    17   RAM byte-address bits (128 KiB), taken from addr[ADDR_WIDTH-1:0]
//  TX_DEPTH      16   TX FIFO entries (power of 2, >=4)
//  RX_DEPTH      16   RX FIFO entries (power of 2, >=2)
//  RAM_INIT_FILE ""   $readmemh image; empty = RAM left uninitialised
// PORTS
//  clk          in   1   clock (all logic on posedge)
//  rst          in   1   synchronous, active-high reset
//  rdy          in   1   global enable; rdy=0 freezes all state, outputs hold
//  in_ram_rw    in   1   0 read, 1 write
//  in_ram_addr  in   32  byte address
//  in_ram_data  in   8   write byte
//  out_ram_data out  8   read byte, registered, valid cycle after address
//  out_io_full  out  1   TX FIFO near full; controller must not start an IO write
//  out_tx_valid out  1   TX byte available to host
//  out_tx_data  out  8   TX FIFO head
//  in_tx_ready  in   1   host accepts head this cycle when valid
//  in_rx_valid  in   1   host offers RX byte
//  in_rx_data   in   8   RX byte
//  out_rx_ready out  1   RX FIFO not full
//  out_sim_end  out  1   one-cycle pulse on write to 0x30004
//  out_overflow out  1   sticky: TX write dropped (FIFO full)
// BEHAVIOUR
//  - Reset: out_ram_data=0, out_io_full=0, out_tx_valid=0, out_tx_data=0 (don't-care once empty), out_rx_ready=1,
//    out_sim_end=0, out_overflow=0, both FIFO ptrs/counts=0. RAM contents NOT cleared by reset.
//  - Decode: io = addr[17:16]==2'b11; io_port = addr[2:0] (0 = data, 4 = end); other IO offsets: write ignored, read 0.
//  - RAM read (rw=0, !io): out_ram_data <= ram[addr[ADDR_WIDTH-1:0]] next edge; 1-cycle latency, one byte/cycle streaming.
//  - RAM write (rw=1, !io): ram[a] <= in_ram_data at edge; out_ram_data unchanged. Read-after-write same addr next cycle returns new byte.
//  - IO read 0x30000: side-effecting; pops RX FIFO in that cycle, out_ram_data <= head next edge; RX empty -> 0x00, no pop.
//    Each cycle the address equals 0x30000 with rw=0 is one pop (initiator presents it exactly one cycle).
//  - IO write 0x30000: push in_ram_data to TX; if TX full: drop, set out_overflow (cleared only by rst).
//  - IO write 0x30004: out_sim_end=1 for exactly one cycle; byte ignored.
//  - TX pop: out_tx_valid && in_tx_ready. Simultaneous push+pop: count unchanged, both happen (full FIFO accepts push when popping).
//  - RX push: in_rx_valid && out_rx_ready. Simultaneous RX push + IO-read pop allowed; empty FIFO: pushed byte not bypassed (read returns 0).
//  - out_io_full registered: <= (tx_count_next >= TX_DEPTH-2); gives >=2 free slots covering controller's 2-cycle uart check lag.
//  - out_rx_ready registered: <= (rx_count_next != RX_DEPTH).
//  - Pointers wrap modulo depth; count width clog2(depth)+1 distinguishes full/empty.
//  - rdy=0: no RAM write, no FIFO push/pop, sim_end held low-pulse suppressed; host handshakes not accepted.
//  - rst mid-stream: FIFOs flushed, in-flight read data discarded (out_ram_data=0).
// STRUCTURE
//  - Shared package/constants file: IO_BASE_SEL 2'b11, IO_DATA_ADDR 32'h30000, IO_END_ADDR 32'h30004, DATA_WIDTH macro.
//  - Sub-module: byte_fifo (param DEPTH; push/pop/data/count/full/empty), instantiated twice (TX, RX).
//  - Top: decode, RAM array + read register, io_full/rx_ready/sim_end/overflow regs.
// TESTING
//  - RAM stream: write 0xA1..0xA4 to 0x100..0x103, read 0x100..0x103 back-to-back -> out_ram_data A1,A2,A3,A4 on cycles t+1..t+4.
//  - TX: 14 writes of 0x41 to 0x30000 with in_tx_ready=0 -> out_io_full=1 after 14th (DEPTH 16); 17th write -> out_overflow=1, count 16.
//  - TX drain: in_tx_ready=1 -> 16 bytes 0x41 emitted one/cycle, out_tx_valid falls, out_io_full clears when count<14.
//  - RX: host pushes 0x55,0x66; two IO reads of 0x30000 -> 0x55 then 0x66; third read -> 0x00.
//  - Write 0x30004 -> out_sim_end high exactly one cycle; rdy=0 during write -> no pulse, no RAM/FIFO change.
//  - rst asserted with 3 TX bytes queued and a read pending -> next cycle all outputs at reset values, tx_valid=0.

Source files
------------

// File: rtl/ram_io_responder_pkg.sv
// Shared constants, bus payload type and IO decode helper for the RAM/IO responder.
package ram_io_responder_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned BUS_ADDR_WIDTH = 32;

  localparam logic [1:0] IO_BASE_SEL = 2'b11;
  localparam logic [BUS_ADDR_WIDTH-1:0] IO_DATA_ADDR = 32'h0003_0000;
  localparam logic [BUS_ADDR_WIDTH-1:0] IO_END_ADDR = 32'h0003_0004;

  // One bus beat as presented by the memory controller.
  typedef struct packed {
    logic                      rw;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } ram_req_t;

  // IO space is selected by address bits 17:16 alone.
  function automatic logic is_io(input logic [BUS_ADDR_WIDTH-1:0] addr);
    return addr[17:16] == IO_BASE_SEL;
  endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte FIFO with registered pointers/count; head is presented combinationally, zero when empty.
module byte_fifo
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CW-1:0]         count_o,
  output logic [CW-1:0]         count_next_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));
  assign pop_ok       = pop_i && !empty_o;
  // A full FIFO still takes a push in the same cycle it is popped.
  assign push_ok      = push_i && (!full_o || pop_ok);
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign data_o       = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer/count state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Responder for the byte-serial RAM bus: byte RAM plus memory-mapped TX/RX FIFOs and program-end strobe.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 17,
  parameter int unsigned TX_DEPTH      = 16,
  parameter int unsigned RX_DEPTH      = 16,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      in_ram_rw,
  input  logic [BUS_ADDR_WIDTH-1:0] in_ram_addr,
  input  logic [DATA_WIDTH-1:0]     in_ram_data,
  output logic [DATA_WIDTH-1:0]     out_ram_data,
  output logic                      out_io_full,
  output logic                      out_tx_valid,
  output logic [DATA_WIDTH-1:0]     out_tx_data,
  input  logic                      in_tx_ready,
  input  logic                      in_rx_valid,
  input  logic [DATA_WIDTH-1:0]     in_rx_data,
  output logic                      out_rx_ready,
  output logic                      out_sim_end,
  output logic                      out_overflow
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

  ram_req_t              req;
  logic                  io_sel, data_port, end_port;
  logic                  ram_wr, tx_push, tx_pop, rx_push, rx_pop;
  logic [ADDR_WIDTH-1:0] ram_addr;

  logic [DATA_WIDTH-1:0] ram_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  io_full_q, io_full_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  sim_end_q, sim_end_d;
  logic                  overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] tx_head, rx_head;
  logic [TX_CW-1:0]      tx_count, tx_count_next;
  logic [RX_CW-1:0]      rx_count, rx_count_next;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  unused_ok;

  assign req = '{rw: in_ram_rw, addr: in_ram_addr, data: in_ram_data};

  // Address decode and per-cycle strobes; rdy=0 suppresses every side effect.
  assign io_sel    = is_io(req.addr);
  assign data_port = io_sel && (req.addr[2:0] == IO_DATA_ADDR[2:0]);
  assign end_port  = io_sel && (req.addr[2:0] == IO_END_ADDR[2:0]);
  assign ram_addr  = req.addr[ADDR_WIDTH-1:0];
  assign ram_wr    = rdy && req.rw && !io_sel;
  assign tx_push   = rdy && req.rw && data_port;
  assign tx_pop    = rdy && !tx_empty && in_tx_ready;
  assign rx_push   = rdy && in_rx_valid && rx_ready_q;
  assign rx_pop    = rdy && !req.rw && data_port;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (tx_push),
    .pop_i        (tx_pop),
    .data_i       (req.data),
    .data_o       (tx_head),
    .count_o      (tx_count),
    .count_next_o (tx_count_next),
    .full_o       (tx_full),
    .empty_o      (tx_empty)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (rx_push),
    .pop_i        (rx_pop),
    .data_i       (in_rx_data),
    .data_o       (rx_head),
    .count_o      (rx_count),
    .count_next_o (rx_count_next),
    .full_o       (rx_full),
    .empty_o      (rx_empty)
  );

  // Next values for read data, flow-control flags, end strobe and sticky overflow.
  always_comb begin
    rd_data_d  = rd_data_q;
    io_full_d  = (tx_count_next >= TX_CW'(TX_DEPTH - 2));
    rx_ready_d = (rx_count_next != RX_CW'(RX_DEPTH));
    sim_end_d  = rdy && req.rw && end_port;
    overflow_d = overflow_q || (tx_push && tx_full && !tx_pop);
    if (rdy && !req.rw) begin
      if (io_sel) begin
        // RX head is already zero when the FIFO is empty; other IO offsets read zero.
        rd_data_d = data_port ? rx_head : '0;
      end else begin
        rd_data_d = ram_q[ram_addr];
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      io_full_q  <= 1'b0;
      rx_ready_q <= 1'b1;
      sim_end_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      io_full_q  <= io_full_d;
      rx_ready_q <= rx_ready_d;
      sim_end_q  <= sim_end_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte RAM write port; contents survive reset and start uninitialised.
  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[ram_addr] <= req.data;
  end

  assign out_ram_data = rd_data_q;
  assign out_io_full  = io_full_q;
  assign out_tx_valid = !tx_empty;
  assign out_tx_data  = tx_head;
  assign out_rx_ready = rx_ready_q;
  assign out_sim_end  = sim_end_q;
  assign out_overflow = overflow_q;

  // Address bits outside the decode, spare FIFO status and the preload name are not needed here.
  assign unused_ok = ^{req.addr, tx_count, rx_count, rx_full, rx_empty, (RAM_INIT_FILE != "")};

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: RAM streaming, TX/RX FIFOs, sim_end, rdy gating and reset.
module tb_ram_io_responder;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        in_ram_rw;
  logic [31:0] in_ram_addr;
  logic [7:0]  in_ram_data;
  logic [7:0]  out_ram_data;
  logic        out_io_full;
  logic        out_tx_valid;
  logic [7:0]  out_tx_data;
  logic        in_tx_ready;
  logic        in_rx_valid;
  logic [7:0]  in_rx_data;
  logic        out_rx_ready;
  logic        out_sim_end;
  logic        out_overflow;

  int vectors;
  int miscompares;

  ram_io_responder dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .in_ram_rw    (in_ram_rw),
    .in_ram_addr  (in_ram_addr),
    .in_ram_data  (in_ram_data),
    .out_ram_data (out_ram_data),
    .out_io_full  (out_io_full),
    .out_tx_valid (out_tx_valid),
    .out_tx_data  (out_tx_data),
    .in_tx_ready  (in_tx_ready),
    .in_rx_valid  (in_rx_valid),
    .in_rx_data   (in_rx_data),
    .out_rx_ready (out_rx_ready),
    .out_sim_end  (out_sim_end),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic rw, input logic [31:0] addr, input logic [7:0] data);
    in_ram_rw   = rw;
    in_ram_addr = addr;
    in_ram_data = data;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    rdy         = 1'b1;
    in_tx_ready = 1'b0;
    in_rx_valid = 1'b0;
    in_rx_data  = 8'h00;
    bus(1'b0, 32'h100, 8'h00);

    // Reset values
    step();
    step();
    check("rst_ram_data", out_ram_data, 8'h00);
    check("rst_io_full", out_io_full, 8'h0);
    check("rst_tx_valid", out_tx_valid, 8'h0);
    check("rst_tx_data", out_tx_data, 8'h00);
    check("rst_rx_ready", out_rx_ready, 8'h1);
    check("rst_sim_end", out_sim_end, 8'h0);
    check("rst_overflow", out_overflow, 8'h0);
    rst = 1'b0;

    // RAM writes leave read data alone, then stream back one byte per cycle
    for (int i = 0; i < 4; i++) begin
      bus(1'b1, 32'h100 + 32'(i), 8'hA1 + 8'(i));
      step();
    end
    check("ram_wr_no_rdata", out_ram_data, 8'h00);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 32'h100 + 32'(i), 8'h00);
      step();
      check("ram_stream", out_ram_data, 8'hA1 + 8'(i));
    end
    bus(1'b0, 32'h100, 8'h00);

    // TX fill with host stalled: near-full after 14, overflow on the 17th
    for (int i = 1; i <= 17; i++) begin
      bus(1'b1, 32'h0003_0000, 8'h41);
      step();
      if (i == 13) check("tx_full_13", out_io_full, 8'h0);
      if (i == 14) check("tx_full_14", out_io_full, 8'h1);
      if (i == 16) check("tx_ovf_16", out_overflow, 8'h0);
    end
    check("tx_ovf_17", out_overflow, 8'h1);
    check("tx_valid_fill", out_tx_valid, 8'h1);
    check("tx_head_fill", out_tx_data, 8'h41);
    bus(1'b0, 32'h100, 8'h00);

    // TX drain, one byte per cycle
    in_tx_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("tx_drain_valid", out_tx_valid, (k != 16) ? 8'h1 : 8'h0);
      check("tx_drain_full", out_io_full, ((16 - k) >= 14) ? 8'h1 : 8'h0);
      if (k != 16) check("tx_drain_data", out_tx_data, 8'h41);
    end
    check("tx_ovf_sticky", out_overflow, 8'h1);
    in_tx_ready = 1'b0;

    // RX: host pushes two bytes, IO reads pop them, then empty reads zero
    in_rx_valid = 1'b1;
    in_rx_data  = 8'h55;
    step();
    in_rx_data  = 8'h66;
    step();
    in_rx_valid = 1'b0;
    check("rx_ready", out_rx_ready, 8'h1);
    bus(1'b0, 32'h0003_0000, 8'h00);
    step();
    check("rx_pop1", out_ram_data, 8'h55);
    step();
    check("rx_pop2", out_ram_data, 8'h66);
    step();
    check("rx_pop_empty", out_ram_data, 8'h00);
    bus(1'b0, 32'h100, 8'h00);
    step();
    check("ram_reread", out_ram_data, 8'hA1);
    bus(1'b0, 32'h0003_0002, 8'h00);
    step();
    check("io_other_rd", out_ram_data, 8'h00);
    bus(1'b0, 32'h100, 8'h00);
    step();
    check("ram_reread2", out_ram_data, 8'hA1);

    // RX push and pop in the same cycle on an empty FIFO: no bypass
    in_rx_valid = 1'b1;
    in_rx_data  = 8'h77;
    bus(1'b0, 32'h0003_0000, 8'h00);
    step();
    in_rx_valid = 1'b0;
    check("rx_no_bypass", out_ram_data, 8'h00);
    step();
    check("rx_after_bypass", out_ram_data, 8'h77);
    bus(1'b0, 32'h100, 8'h00);
    step();

    // sim_end pulse lasts exactly one cycle
    bus(1'b1, 32'h0003_0004, 8'hFF);
    step();
    check("sim_end_pulse", out_sim_end, 8'h1);
    bus(1'b0, 32'h100, 8'h00);
    step();
    check("sim_end_clear", out_sim_end, 8'h0);
    check("ram_before_rdy", out_ram_data, 8'hA1);

    // rdy=0 freezes everything
    rdy = 1'b0;
    bus(1'b1, 32'h0003_0004, 8'hFF);
    step();
    check("rdy_no_sim_end", out_sim_end, 8'h0);
    bus(1'b1, 32'h100, 8'h99);
    step();
    bus(1'b1, 32'h0003_0000, 8'h5A);
    step();
    bus(1'b0, 32'h101, 8'h00);
    step();
    check("rdy_hold_rdata", out_ram_data, 8'hA1);
    check("rdy_no_tx_push", out_tx_valid, 8'h0);
    rdy = 1'b1;
    bus(1'b0, 32'h100, 8'h00);
    step();
    check("rdy_no_ram_wr", out_ram_data, 8'hA1);
    check("rdy_no_tx_push2", out_tx_valid, 8'h0);

    // TX simultaneous push and pop
    bus(1'b1, 32'h0003_0000, 8'h77);
    step();
    check("tx_one_head", out_tx_data, 8'h77);
    bus(1'b1, 32'h0003_0000, 8'h88);
    in_tx_ready = 1'b1;
    step();
    check("tx_pushpop_valid", out_tx_valid, 8'h1);
    check("tx_pushpop_head", out_tx_data, 8'h88);
    bus(1'b0, 32'h100, 8'h00);
    step();
    check("tx_pushpop_drain", out_tx_valid, 8'h0);
    in_tx_ready = 1'b0;

    // Reset mid-stream with TX bytes queued and a read in flight
    bus(1'b1, 32'h0003_0000, 8'h11);
    step();
    bus(1'b1, 32'h0003_0000, 8'h22);
    step();
    bus(1'b1, 32'h0003_0000, 8'h33);
    step();
    check("pre_rst_head", out_tx_data, 8'h11);
    bus(1'b0, 32'h101, 8'h00);
    step();
    check("pre_rst_rdata", out_ram_data, 8'hA2);
    bus(1'b0, 32'h102, 8'h00);
    rst = 1'b1;
    step();
    check("mid_rst_ram_data", out_ram_data, 8'h00);
    check("mid_rst_tx_valid", out_tx_valid, 8'h0);
    check("mid_rst_tx_data", out_tx_data, 8'h00);
    check("mid_rst_io_full", out_io_full, 8'h0);
    check("mid_rst_rx_ready", out_rx_ready, 8'h1);
    check("mid_rst_overflow", out_overflow, 8'h0);
    check("mid_rst_sim_end", out_sim_end, 8'h0);
    rst = 1'b0;
    bus(1'b0, 32'h100, 8'h00);
    step();
    check("post_rst_tx_valid", out_tx_valid, 8'h0);
    check("post_rst_ram_kept", out_ram_data, 8'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
